// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants and the ShiftRows row-offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int TEXT_WIDTH     = 128;
    localparam int COL_WIDTH      = 32;
    localparam int NB_LEGAL_COUNT = 3;
    localparam int NB_LEGAL [NB_LEGAL_COUNT] = '{4, 6, 8};

    function automatic bit nb_is_legal(input int nb);
        bit w_ok;
        w_ok = 1'b0;
        for (int i = 0; i < NB_LEGAL_COUNT; i++) begin
            if (NB_LEGAL[i] == nb) begin
                w_ok = 1'b1;
            end
        end
        return w_ok;
    endfunction

    // Rijndael row offsets: rows 2 and 3 move one further for 256-bit blocks.
    function automatic int shift_offset(input int nb, input int r);
        if (nb == 8 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : aes_pipe_stage
// Description : One valid/data register slice with elastic advance logic.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_pipe_stage #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_next_ready,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_advance;

    // An empty slot always accepts, which is what lets bubbles collapse.
    assign w_advance = !r_valid || i_next_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_advance) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_ready = w_advance;
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/aes_shiftrows_pipe.sv
`default_nettype none
// ============================================================================
// Module      : aes_shiftrows_pipe
// Description : Pipelined (Inv)ShiftRows with valid/ready flow control.
//               Inverse mode is built only when AES_SHIFTROWS_INV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_shiftrows_pipe
    import aes_pkg::*;
#(
    parameter int NB     = 4,
    parameter int STAGES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          inv_i,
    input  logic [COL_WIDTH*NB-1:0]       state_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [COL_WIDTH*NB-1:0]       state_o,
    output logic [$clog2(STAGES+1)-1:0]   occupancy_o
);

    localparam int W     = COL_WIDTH * NB;
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [W-1:0] w_fwd;
    logic [W-1:0] w_perm;

    // Byte r+4c sits at the top of the vector, so byte k is bits [W-1-8k -: 8].
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int S   = shift_offset(NB, r);
            localparam int SRC = (c + S) % NB;
            assign w_fwd[W-1-8*(r+4*c) -: 8] = state_i[W-1-8*(r+4*SRC) -: 8];
        end
    end

`ifdef AES_SHIFTROWS_INV_EN
    logic [W-1:0] w_inv;

    for (genvar r = 0; r < 4; r++) begin : g_irow
        for (genvar c = 0; c < NB; c++) begin : g_icol
            localparam int S   = shift_offset(NB, r);
            localparam int SRC = (c - S + NB) % NB;
            assign w_inv[W-1-8*(r+4*c) -: 8] = state_i[W-1-8*(r+4*SRC) -: 8];
        end
    end

    assign w_perm = inv_i ? w_inv : w_fwd;
`else
    logic w_unused_inv;
    assign w_unused_inv = inv_i;
    assign w_perm       = w_fwd;
`endif

    logic         w_vld  [STAGES+1];
    logic [W-1:0] w_data [STAGES+1];

    assign w_vld[0]  = in_valid_i;
    assign w_data[0] = w_perm;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic w_stage_ready;
        logic w_next_ready;

        if (k == STAGES - 1) begin : g_last
            assign w_next_ready = out_ready_i;
        end else begin : g_mid
            assign w_next_ready = g_stage[k+1].w_stage_ready;
        end

        aes_pipe_stage #(
            .W (W)
        ) u_stage (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_valid      (w_vld[k]),
            .i_data       (w_data[k]),
            .i_next_ready (w_next_ready),
            .o_ready      (w_stage_ready),
            .o_valid      (w_vld[k+1]),
            .o_data       (w_data[k+1])
        );
    end

    assign in_ready_o  = g_stage[0].w_stage_ready;
    assign out_valid_o = w_vld[STAGES];
    assign state_o     = w_data[STAGES];

    logic             w_accept;
    logic             w_drain;
    logic [OCC_W-1:0] r_occupancy;

    assign w_accept = in_valid_i && in_ready_o;
    assign w_drain  = out_valid_o && out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occupancy <= '0;
        end else begin
            case ({w_accept, w_drain})
                2'b10:   r_occupancy <= r_occupancy + OCC_W'(1);
                2'b01:   r_occupancy <= r_occupancy - OCC_W'(1);
                default: r_occupancy <= r_occupancy;
            endcase
        end
    end

    assign occupancy_o = r_occupancy;

endmodule
`default_nettype wire

// File: tb/tb_aes_shiftrows_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_shiftrows_pipe
// Description : Scoreboard bench for aes_shiftrows_pipe (NB=4/STAGES=3, NB=8/STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_shiftrows_pipe;

    localparam int S4 = 3;
    localparam int S8 = 2;
`ifdef AES_SHIFTROWS_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif
    localparam int OFF4 [4] = '{0, 1, 2, 3};
    localparam int OFF8 [4] = '{0, 1, 3, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         v4, r4o, inv4, ov4, ordy4;
    logic [127:0] st4, so4;
    logic [1:0]   occ4;
    logic         v8, r8o, inv8, ov8, ordy8;
    logic [255:0] st8, so8;
    logic [1:0]   occ8;

    int total = 0;
    int bad   = 0;
    logic [127:0] q4 [$];
    logic [255:0] q8 [$];
    bit bp_rand = 1'b0;

    aes_shiftrows_pipe #(.NB(4), .STAGES(S4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(v4), .in_ready_o(r4o), .inv_i(inv4),
        .state_i(st4), .out_valid_o(ov4), .out_ready_i(ordy4), .state_o(so4),
        .occupancy_o(occ4)
    );

    aes_shiftrows_pipe #(.NB(8), .STAGES(S8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(v8), .in_ready_o(r8o), .inv_i(inv8),
        .state_i(st8), .out_valid_o(ov8), .out_ready_i(ordy8), .state_o(so8),
        .occupancy_o(occ8)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: rotate each row of an NB-column byte matrix by its offset.
    function automatic logic [255:0] ref_shift(input logic [255:0] st, input int nb, input bit inv);
        logic [255:0] res = '0;
        int w = 32 * nb;
        for (int r = 0; r < 4; r++) begin
            int s = (nb == 8) ? OFF8[r] : OFF4[r];
            for (int c = 0; c < nb; c++) begin
                int src = inv ? (c - s + nb) % nb : (c + s) % nb;
                res[w-1-8*(r+4*c) -: 8] = st[w-1-8*(r+4*src) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] m4(input logic [127:0] d, input bit inv);
        logic [255:0] t;
        t = ref_shift({128'b0, d}, 4, inv & INV_EN);
        return t[127:0];
    endfunction

    function automatic logic [255:0] m8(input logic [255:0] d, input bit inv);
        return ref_shift(d, 8, inv & INV_EN);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    task automatic send4(input logic [127:0] d, input bit inv, input logic [127:0] exp);
        int n = 0;
        bit acc = 1'b0;
        v4 = 1'b1; st4 = d; inv4 = inv;
        while (!acc && n < 100) begin
            @(negedge clk); acc = r4o;
            @(posedge clk); #1; n++;
        end
        v4 = 1'b0;
        if (acc) q4.push_back(exp);
        else chk("send4_timeout", 0, 1);
    endtask

    task automatic send8(input logic [255:0] d, input bit inv, input logic [255:0] exp);
        int n = 0;
        bit acc = 1'b0;
        v8 = 1'b1; st8 = d; inv8 = inv;
        while (!acc && n < 100) begin
            @(negedge clk); acc = r8o;
            @(posedge clk); #1; n++;
        end
        v8 = 1'b0;
        if (acc) q8.push_back(exp);
        else chk("send8_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < 300) begin
            @(posedge clk); n++;
        end
        #1;
        chk("drain_left", q4.size() + q8.size(), 0);
    endtask

    initial begin : mon4
        logic         hold = 1'b0;
        logic [127:0] prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid4", ov4, 1);
                    chk("hold_data4", so4, prev);
                end
                if (ov4 && ordy4) begin
                    if (q4.size() == 0) chk("unexpected_out4", 1, 0);
                    else chk("data4", so4, q4.pop_front());
                end
                hold = ov4 && !ordy4;
                prev = so4;
            end
        end
    end

    initial begin : mon8
        logic         hold = 1'b0;
        logic [255:0] prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid8", ov8, 1);
                    chk("hold_data8", so8, prev);
                end
                if (ov8 && ordy8) begin
                    if (q8.size() == 0) chk("unexpected_out8", 1, 0);
                    else chk("data8", so8, q8.pop_front());
                end
                hold = ov8 && !ordy8;
                prev = so8;
            end
        end
    end

    initial begin : bp
        forever begin
            @(posedge clk); #1;
            if (bp_rand) begin
                ordy4 = 1'($urandom);
                ordy8 = 1'($urandom);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] pend;
        logic [255:0] d8;
        bit pinv, have, acc;
        int sent, seen;

        rst_n = 1'b0;
        v4 = 0; inv4 = 0; st4 = '0; ordy4 = 1;
        v8 = 0; inv8 = 0; st8 = '0; ordy8 = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ov4", ov4, 0);  chk("rst_occ4", occ4, 0); chk("rst_so4", so4, 0);
        chk("rst_ov8", ov8, 0);  chk("rst_occ8", occ8, 0); chk("rst_so8", so8, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready4", r4o, 1); chk("rel_ready8", r8o, 1);
        @(posedge clk); #1;

        // Latency from the accepting edge with an idle pipeline.
        v4 = 1; st4 = 128'h000102030405060708090a0b0c0d0e0f; inv4 = 0;
        @(negedge clk); chk("lat_ready", r4o, 1);
        @(posedge clk); #1; v4 = 0;
        q4.push_back(128'h00050a0f04090e03080d02070c01060b);
        for (int k = 1; k <= S4; k++) begin
            @(negedge clk);
            chk("latency_valid", ov4, (k == S4));
        end
        @(posedge clk); #1;

        send4(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
`ifdef AES_SHIFTROWS_INV_EN
        send4(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230);
`endif
        for (int k = 0; k < 32; k++) d8[255-8*k -: 8] = 8'(k);
        send8(d8, 1'b0, m8(d8, 1'b0));
        wait_drain();

        // Ten back-to-back beats with the sink always ready.
        for (int i = 0; i < 14; i++) begin
            if (i < 10) begin
                v4 = 1; st4 = rnd128(); inv4 = 1'($urandom);
            end else begin
                v4 = 0;
            end
            @(negedge clk);
            acc = v4 && r4o;
            if (i < 10) chk("stream_ready", r4o, 1);
            chk("stream_valid", ov4, (i >= 3 && i <= 12));
            chk("stream_occ", occ4, (i <= 3) ? i : ((i <= 10) ? 3 : 13 - i));
            @(posedge clk); #1;
            if (acc) q4.push_back(m4(st4, inv4));
        end
        v4 = 0;
        wait_drain();

        // Backpressure for five cycles while input keeps streaming.
        sent = 0; have = 0; pinv = 0; pend = '0;
        for (int i = 0; i < 7; i++) begin
            ordy4 = (i >= 5);
            if (sent < 4) begin
                if (!have) begin pend = rnd128(); pinv = 1'($urandom); have = 1; end
                v4 = 1; st4 = pend; inv4 = pinv;
            end else begin
                v4 = 0;
            end
            @(negedge clk);
            acc = v4 && r4o;
            chk("bp_ready", r4o, (i < 3 || i >= 5));
            chk("bp_occ", occ4, (i < 3) ? i : 3);
            @(posedge clk); #1;
            if (acc) begin q4.push_back(m4(pend, pinv)); have = 0; sent++; end
        end
        v4 = 0; ordy4 = 1;
        wait_drain();
        chk("bp_sent", sent, 4);

        // Random mixed-mode traffic with random backpressure.
        bp_rand = 1;
        for (int n = 0; n < 160; n++) begin
            pinv = 1'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                pend = rnd128();
                send4(pend, pinv, m4(pend, pinv));
            end else begin
                d8 = rnd256();
                send8(d8, pinv, m8(d8, pinv));
            end
            if ($urandom_range(3, 0) == 0) begin @(posedge clk); #1; end
        end
        bp_rand = 0;
        @(posedge clk); #1;
        ordy4 = 1; ordy8 = 1;
        wait_drain();

        // Reset with beats in flight.
        ordy4 = 0; ordy8 = 0;
        send4(rnd128(), 1'b0, '0);
        send4(rnd128(), 1'b0, '0);
        send8(rnd256(), 1'b0, '0);
        #2; rst_n = 1'b0;
        #1;
        chk("mid_rst_ov4", ov4, 0); chk("mid_rst_occ4", occ4, 0); chk("mid_rst_so4", so4, 0);
        chk("mid_rst_ov8", ov8, 0); chk("mid_rst_occ8", occ8, 0);
        q4.delete(); q8.delete();
        @(posedge clk); #1; rst_n = 1'b1; ordy4 = 1; ordy8 = 1;
        @(negedge clk);
        chk("post_rst_ready4", r4o, 1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ov4 || ov8) seen++;
        end
        chk("post_rst_ghost", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_shiftrows_pipe.md
AES_SHIFTROWS_PIPE -- requirements
Module: aes_shiftrows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4, meaning the number of 32-bit state columns; legal values are 4, 6 and 8.
REQ-002 SHALL have parameter STAGES, default 1, meaning the number of register stages; legal values are 1 to 4.
REQ-003 SHALL have port clk, input, width 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, width 1, the reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid_i, input, width 1, meaning input beat offered.
REQ-006 SHALL have port in_ready_o, output, width 1, meaning input beat accepted this cycle when high with in_valid_i.
REQ-007 SHALL have port inv_i, input, width 1, meaning the mode: 0 is forward ShiftRows, 1 is InvShiftRows; sampled with the beat.
REQ-008 SHALL have port state_i, input, width 32*NB, meaning the state; column-major, byte 0 in the MSBs, row r of column c in byte r+4c.
REQ-009 SHALL have port out_valid_o, output, width 1, meaning a result is available.
REQ-010 SHALL have port out_ready_i, input, width 1, meaning the downstream accepts the result.
REQ-011 SHALL have port state_o, output, width 32*NB, meaning the shifted state, using the same byte order as state_i.
REQ-012 SHALL have port occupancy_o, output, width clog2(STAGES+1), meaning the number of valid stages.

Function
REQ-013 SHALL shift row r, forward, as: out(r,c) = in(r,(c+s_r) mod NB); inverse: out(r,c) = in(r,(c-s_r+NB) mod NB).
REQ-014 SHALL use offsets s_0..s_3 of 0,1,2,3 for NB=4 and NB=6, and 0,1,3,4 for NB=8.
REQ-015 SHALL compute the permutation combinationally on input; the result, with its valid bit, SHALL be captured in stage 0.
REQ-016 SHALL give a latency of exactly STAGES cycles from the accepting edge to out_valid_o high when there is no backpressure.
REQ-017 SHALL advance stage k when stage k is empty, or stage k+1 advances, or k is the last stage and out_ready_i is high.
REQ-018 SHALL give in_ready_o = !stage0_valid || stage0_advances; it is combinational from out_ready_i, and bubbles collapse.
REQ-019 SHALL sustain full throughput of one beat per cycle with out_ready_i held high.
REQ-020 SHALL hold state_o and out_valid_o stable while out_valid_o && !out_ready_i.
REQ-021 SHALL drop no beat and duplicate no beat when full with a simultaneous accept and drain; occupancy_o SHALL be unchanged in that case.
REQ-022 SHALL increment occupancy_o on accept-only, decrement it on drain-only, and hold it otherwise.
REQ-023 SHALL give each in-flight beat its own mode, so mixed forward and inverse beats interleave correctly.

Reset
REQ-024 SHALL, on rst_n low, immediately clear all stage valid bits, giving out_valid_o=0 and occupancy_o=0, and in_ready_o=1 once reset is released.
REQ-025 SHALL reset data registers to zero, so state_o=0 in reset.
REQ-026 SHALL discard in-flight beats on mid-operation reset; there is no partial output after release.

Configuration
REQ-027 SHALL use macro AES_SHIFTROWS_INV_EN: when defined, inverse mode is per REQ-013; when undefined, inv_i is ignored and treated as 0, and no inverse mux is synthesised.

Structure
REQ-028 SHALL take TEXT_WIDTH, legal NB values and a function returning s_r for (NB,r) from the shared package aes_pkg.
REQ-029 SHALL implement each stage as one instance of sub-module aes_pipe_stage (valid/data register slice with advance logic), generated STAGES times.

Verification
REQ-030 SHALL check: NB=4, forward, state_i=000102030405060708090a0b0c0d0e0f -> state_o=00050a0f04090e03080d02070c01060b after STAGES cycles.
REQ-031 SHALL check: NB=4, FIPS-197 round 1, forward d42711aee0bf98f1b8b45de51e415230 -> d4bf5d30e0b452aeb84111f11e2798e5; then inverse of that output -> the original value.
REQ-032 SHALL check: STAGES=3, with 10 back-to-back beats and out_ready_i=1 -> 10 outputs on consecutive cycles, in order, with occupancy_o=3 at steady state.
REQ-033 SHALL check: out_ready_i=0 for 5 cycles with input streaming -> in_ready_o low once occupancy_o=STAGES, state_o stable, no loss after release.
REQ-034 SHALL check: NB=8, forward, state_i bytes 00..1f -> row 1 taken from columns c+1, row 2 from c+3, row 3 from c+4 (mod 8), compared against the reference model.
REQ-035 SHALL check: rst_n pulsed low with 2 beats in flight -> out_valid_o=0 and occupancy_o=0 immediately, and neither beat appears after release.
